// File: rtl/seg_pkg.sv
// seg_pkg: seven-segment pattern table and sizes shared by the display encoder and capture.
package seg_pkg;
  localparam int DIGITS = 8;
  localparam int SAMPLE_W = DIGITS + 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
endpackage

// File: rtl/seg_decode.sv
// seg_decode: maps an active-low a_to_g pattern back to its hex nibble.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] a_to_g,
  output logic       valid,
  output logic [3:0] nibble
);
  always_comb begin
    valid = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++)
      if (a_to_g == SEG_PAT[i]) begin
        valid = 1'b1;
        nibble = 4'(i);
      end
  end
endmodule

// File: rtl/seg_capture.sv
// seg_capture: debounces the multiplexed seven-segment bus and rebuilds the displayed digit image.
module seg_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk_,
  input  logic                  rst_,
  input  logic                  clear,
  input  logic [6:0]            a_to_g,
  input  logic [DIGITS-1:0]     AN_,
  input  logic                  dp_,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_valid,
  output logic [DIGITS-1:0]     dp_on,
  output logic [DIGITS-1:0]     bad_pattern,
  output logic                  multi_an,
  output logic                  frame_done
);
  localparam logic [7:0] STB = 8'(STABLE_CYCLES);
  logic [SAMPLE_W-1:0] sample, s_q;
  logic [7:0] cnt;
  logic accept, multi, one_hot, valid;
  logic [DIGITS-1:0] seen, sel;
  logic [3:0] nibble;
  assign sample = {AN_, a_to_g, dp_};
  assign sel = ~s_q[SAMPLE_W-1:8];
  assign multi = |(sel & (sel - 1'b1));
  assign one_hot = |sel && !multi;
  seg_decode u_dec (.a_to_g(s_q[7:1]), .valid(valid), .nibble(nibble));
  // s_q/cnt keep running through clear so a static bus is not re-accepted
  always_ff @(posedge clk_) begin
    if (rst_) begin
      s_q <= {{DIGITS{1'b1}}, SEG_BLANK, 1'b1};
      cnt <= '0;
      accept <= 1'b0;
      digits <= '0;
      digit_valid <= '0;
      dp_on <= '0;
      bad_pattern <= '0;
      multi_an <= 1'b0;
      frame_done <= 1'b0;
      seen <= '0;
    end else begin
      if (sample != s_q) begin
        s_q <= sample;
        cnt <= '0;
      end else if (cnt < STB) cnt <= cnt + 8'd1;
      accept <= sample == s_q && cnt == STB - 8'd1;
      frame_done <= 1'b0;
      if (clear) begin
        digits <= '0;
        digit_valid <= '0;
        dp_on <= '0;
        bad_pattern <= '0;
        multi_an <= 1'b0;
        seen <= '0;
      end else if (accept && one_hot) begin
        for (int k = 0; k < DIGITS; k++)
          if (sel[k]) begin
            if (valid) begin
              digits[4*k+:4] <= nibble;
              digit_valid[k] <= 1'b1;
              dp_on[k] <= ~s_q[0];
            end else begin
              bad_pattern[k] <= 1'b1;
              digit_valid[k] <= 1'b0;
            end
          end
        frame_done <= (seen | sel) == '1;
        seen <= (seen | sel) == '1 ? '0 : seen | sel;
      end else if (accept && multi) multi_an <= 1'b1;
    end
  end
endmodule

// File: doc/seg_capture.md
# seg_capture

Display-bus capture block: the receiving end of the multiplexed seven-segment interface (active-low a_to_g, AN_, dp_) driven by our hex-to-seven-segment display logic. It samples the bus, waits for each anode/segment combination to settle, decodes each pattern back to a hex nibble, and builds an 8-digit register image. The result is used for on-board self-check and by benches to read back what the RSA datapath displayed.

## Interface
- STABLE_CYCLES, 4: consecutive matching samples needed before a bus state is accepted. Range 1..255.

- clk_  in  1  Only clock; all state updates on its rising edge.
- rst_  in  1  Synchronous, active-high reset.
- clear  in  1  Synchronous clear of the capture image.
- a_to_g  in  7  Active-low segments; bit6=a … bit0=g.
- AN_  in  8  Active-low anodes; bit k low selects digit k.
- dp_  in  1  Active-low decimal point.
- digits  out  32  Digit k at [4k+3:4k].
- digit_valid  out  8  Bit k set when digit k holds a decoded value.
- dp_on  out  8  Bit k is the decimal-point state captured with digit k (1 = lit).
- bad_pattern  out  8  Sticky; bit k set when digit k showed an undecodable pattern.
- multi_an  out  1  Sticky; set when more than one anode was low on an accepted state.
- frame_done  out  1  One-cycle pulse when all 8 digits have been accepted since the last pulse, clear, or reset.

## Operation
- Sample register s_q holds {AN_, a_to_g, dp_}. Reset value is {8'hFF, 7'h7F, 1'b1} (blank).
- Stability counter cnt is 8 bits and resets to 0.
  - Sample != s_q: s_q ← sample, cnt ← 0.
  - Sample == s_q and cnt < STABLE_CYCLES: cnt ← cnt+1.
  - Saturates at STABLE_CYCLES.
- accept is a registered pulse, set on the edge where cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. A static bus gives exactly one accept.
- On accept, classify s_q.AN_:
  - 8'hFF: no effect.
  - Exactly one bit k low:
    - Pattern decodes: digits[k] ← value, digit_valid[k] ← 1, dp_on[k] ← ~dp_, seen[k] ← 1.
    - Pattern does not decode: bad_pattern[k] ← 1, digit_valid[k] ← 0, seen[k] ← 1. digits[k] and dp_on[k] are unchanged.
  - Two or more bits low: multi_an ← 1. No digit state changes.
- Decode table (a_to_g → nibble); any other pattern is invalid:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→B
  - 0110001→C, 1000010→D, 0110000→E, 0111000→F
- Frame completion: when seen reaches 8'hFF, frame_done pulses for one cycle and seen clears on the same edge. Re-accepting an already-seen digit overwrites it and does not pulse.
- clear:
  - Zeroes digits, digit_valid, dp_on, bad_pattern, multi_an and seen.
  - Does not touch s_q or cnt, so a bus held static through clear is not re-accepted until it changes.
- Priority: rst_ > clear > accept. An accept in a cycle with clear asserted is discarded.

## Timing
- Reset values: digits=0, digit_valid=0, dp_on=0, bad_pattern=0, multi_an=0, frame_done=0. Internally seen=0, cnt=0, accept=0.
- Latency: first edge sampling a new bus value is E1. accept registers at E(STABLE_CYCLES+1); outputs update at E(STABLE_CYCLES+2). With the default, that is 6 edges.
- Any bus change before E(STABLE_CYCLES+1) restarts the count. Glitches shorter than STABLE_CYCLES+1 samples are never captured.
- frame_done is asserted in the same cycle the 8th digit's outputs become visible.
- rst_ mid-scan: all state returns to reset values at the next edge. Capture restarts from a blank s_q.
- Inputs are assumed synchronous to clk_; there is no CDC synchronizer in this block.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry segment pattern constants, shared with the display encoder so both ends use one table;
  - localparam SEG_BLANK = 7'h7F;
  - the digit count (8).
- Sub-module seg_decode: combinational, a_to_g → {valid, nibble}, using the seg_pkg constants.
- Top level holds s_q, cnt, accept, the one-hot anode check, and the capture and frame registers.

## Test plan
- Reset, then AN_=8'hFE, a_to_g=0000110 held 10 cycles → at edge 6, digits[3:0]=3, digit_valid=8'h01, frame_done stays 0.
- Scan k=0..7 showing value k+1, each held 8 cycles, dp_ low on digit 4 only → digits=32'h87654321, digit_valid=8'hFF, dp_on=8'h10. frame_done is a single pulse, coincident with digit 7's update.
- AN_=8'hFD with a_to_g=0010010 held 3 cycles, then blank → no output change.
- AN_=8'hFB, a_to_g=1111110 held 8 cycles → bad_pattern=8'h04, digit_valid[2]=0, digits[11:8] unchanged.
- AN_=8'hFC with a valid pattern held 8 cycles → multi_an=1; digits and digit_valid unchanged.
- Assert clear on the accept cycle of digit 0 → all outputs 0, no frame_done. Then assert rst_ mid-scan → all outputs at reset values after one edge.
